// File: rtl/pong_btn_cond_if.sv
// Button bundle between the raw board pins, the conditioner and vga_pong.
interface pong_btn_cond_if;
  logic [1:0] btn_raw;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;
  logic [1:0] btn_rep;

  // Board side: drives raw buttons, consumes conditioned outputs
  modport master (
    output btn_raw,
    input  btn_level, btn_press, btn_release, btn_rep
  );

  // Conditioner side
  modport slave (
    input  btn_raw,
    output btn_level, btn_press, btn_release, btn_rep
  );
endinterface

// File: rtl/pong_btn_cond.sv
// Two-channel push-button conditioner: synchronise, debounce, press/release
// pulses and auto-repeat. Channels are identical and independent.
module pong_btn_cond #(
  parameter int DB_COUNT      = 1_000_000,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  parameter int CNT_W         = 25
) (
  input  logic          CLK_50MHZ,
  input  logic          RESET,
  pong_btn_cond_if.slave bus
);

  localparam int NUM_CH = 2;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_COUNT - 1);
  localparam logic [CNT_W-1:0] REP_DLY = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] REP_PER = CNT_W'(REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT1, S_HELD, S_WAIT0} state_t;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic             r_s0, r_s1;
    state_t           r_st;
    logic [CNT_W-1:0] r_dcnt, r_rcnt;
    logic             r_armed;   // first repeat already issued -> use period
    logic             r_lvl, r_press, r_rel, r_rep;
    logic             r_lvl_q, r_press_q, r_rel_q, r_rep_q;

    logic             w_hold, w_rel_now, w_rep_hit;
    logic [CNT_W-1:0] w_rnext, w_rtgt;

    assign w_hold    = (r_st == S_HELD) || (r_st == S_WAIT0);
    assign w_rel_now = (r_st == S_WAIT0) && !r_s1 && (r_dcnt == DB_LAST);
    assign w_rnext   = r_rcnt + ONE;
    assign w_rtgt    = r_armed ? REP_PER : REP_DLY;
    // A repeat landing on the release cycle is dropped
    assign w_rep_hit = w_hold && !w_rel_now && (w_rnext == w_rtgt);

    // Synchroniser, debounce FSM and repeat counter
    always_ff @(posedge CLK_50MHZ or negedge RESET) begin
      if (!RESET) begin
        r_s0    <= 1'b0;
        r_s1    <= 1'b0;
        r_st    <= S_IDLE;
        r_dcnt  <= '0;
        r_rcnt  <= '0;
        r_armed <= 1'b0;
        r_lvl   <= 1'b0;
        r_press <= 1'b0;
        r_rel   <= 1'b0;
        r_rep   <= 1'b0;
      end else begin
        r_s0    <= bus.btn_raw[g];
        r_s1    <= r_s0;
        r_press <= 1'b0;
        r_rel   <= 1'b0;
        r_rep   <= 1'b0;

        // Repeat timer: count-to-target, reload to 0 on each pulse so it never wraps
        if (w_hold && !w_rel_now) begin
          if (w_rep_hit) begin
            r_rep   <= 1'b1;
            r_rcnt  <= '0;
            r_armed <= 1'b1;
          end else begin
            r_rcnt  <= w_rnext;
          end
        end

        case (r_st)
          S_IDLE: begin
            if (r_s1) begin
              r_st   <= S_WAIT1;
              r_dcnt <= ONE;
            end
          end
          S_WAIT1: begin
            if (!r_s1) begin
              r_st <= S_IDLE;
            end else if (r_dcnt == DB_LAST) begin
              r_st    <= S_HELD;
              r_lvl   <= 1'b1;
              r_press <= 1'b1;
              r_rcnt  <= '0;
              r_armed <= 1'b0;
            end else begin
              r_dcnt <= r_dcnt + ONE;
            end
          end
          S_HELD: begin
            if (!r_s1) begin
              r_st   <= S_WAIT0;
              r_dcnt <= ONE;
            end
          end
          S_WAIT0: begin
            if (r_s1) begin
              r_st <= S_HELD;
            end else if (r_dcnt == DB_LAST) begin
              r_st    <= S_IDLE;
              r_lvl   <= 1'b0;
              r_rel   <= 1'b1;
              r_rcnt  <= '0;
              r_armed <= 1'b0;
            end else begin
              r_dcnt <= r_dcnt + ONE;
            end
          end
          default: r_st <= S_IDLE;
        endcase
      end
    end

    // Output register stage: isolates outputs from FSM decode
    always_ff @(posedge CLK_50MHZ or negedge RESET) begin
      if (!RESET) begin
        r_lvl_q   <= 1'b0;
        r_press_q <= 1'b0;
        r_rel_q   <= 1'b0;
        r_rep_q   <= 1'b0;
      end else begin
        r_lvl_q   <= r_lvl;
        r_press_q <= r_press;
        r_rel_q   <= r_rel;
        r_rep_q   <= r_rep;
      end
    end

    assign bus.btn_level[g]   = r_lvl_q;
    assign bus.btn_press[g]   = r_press_q;
    assign bus.btn_release[g] = r_rel_q;
    assign bus.btn_rep[g]     = r_rep_q;
  end

endmodule
